// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory map: region enum,
// default geometry and the address decoder.
package hack_mem_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_SCREEN,
        REG_KBD,
        REG_STAT,
        REG_NONE
    } region_e;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 15;
    localparam int DEF_RAM_DEPTH    = 16384;
    localparam int DEF_SCREEN_DEPTH = 8192;
    localparam int DEF_KBD_DEPTH    = 4;

    // Keyboard data sits right after the screen, status one word later.
    function automatic region_e decode_addr(
        input int addr,
        input int ram_depth,
        input int screen_depth
    );
        int kbd_addr;
        kbd_addr = ram_depth + screen_depth;
        if (addr < ram_depth)
            return REG_RAM;
        else if (addr < kbd_addr)
            return REG_SCREEN;
        else if (addr == kbd_addr)
            return REG_KBD;
        else if (addr == kbd_addr + 1)
            return REG_STAT;
        return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_kbd_fifo.sv
// Keyboard key-code FIFO; pop on empty is ignored, push on full is
// dropped unless a pop frees the slot in the same cycle.
module hack_kbd_fifo
    import hack_mem_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_KBD_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_mmio_memory.sv
// Hack data RAM, screen RAM and keyboard port behind one word address.
// Define HACK_MMIO_KBD_FIFO_EN for a queued keyboard; otherwise a single register.
module hack_mmio_memory
    import hack_mem_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int RAM_DEPTH    = DEF_RAM_DEPTH,
    parameter int SCREEN_DEPTH = DEF_SCREEN_DEPTH,
    parameter int KBD_DEPTH    = DEF_KBD_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic [DATA_W-1:0] kbd_in,
    input  logic              kbd_push,
    output logic              kbd_full,
    output logic              addr_err
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int SCR_AW = $clog2(SCREEN_DEPTH);

    if (KBD_DEPTH < 2 || KBD_DEPTH > 16 ||
        (KBD_DEPTH & (KBD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("KBD_DEPTH must be a power of two in 2..16");
    end

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [SCR_AW-1:0] scr_idx;
    logic [DATA_W-1:0] ram    [RAM_DEPTH];
    logic [DATA_W-1:0] screen [SCREEN_DEPTH];
    logic [DATA_W-1:0] kbd_rd;
    logic [DATA_W-1:0] kbd_stat;

    assign region  = decode_addr(32'(address), RAM_DEPTH, SCREEN_DEPTH);
    assign ram_idx = RAM_AW'(address);
    assign scr_idx = SCR_AW'(address - ADDR_W'(RAM_DEPTH));

    // Arrays are never reset so they can map onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && load && region == REG_RAM)
            ram[ram_idx] <= in;
        if (rst_n && load && region == REG_SCREEN)
            screen[scr_idx] <= in;
    end

`ifdef HACK_MMIO_KBD_FIFO_EN
    logic                       kbd_pop;
    logic                       kbd_empty;
    logic [DATA_W-1:0]          kbd_head;
    logic [$clog2(KBD_DEPTH):0] kbd_count;

    assign kbd_pop = (region == REG_KBD) && !load;

    hack_kbd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (kbd_push),
        .push_data (kbd_in),
        .pop       (kbd_pop),
        .head      (kbd_head),
        .count     (kbd_count),
        .full      (kbd_full),
        .empty     (kbd_empty)
    );

    assign kbd_rd   = kbd_empty ? '0 : kbd_head;
    assign kbd_stat = DATA_W'(kbd_count);
`else
    logic [DATA_W-1:0] kbd_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            kbd_reg <= '0;
        else if (kbd_push)
            kbd_reg <= kbd_in;
    end

    assign kbd_rd   = kbd_reg;
    assign kbd_stat = '0;
    assign kbd_full = 1'b0;
`endif

    // Nonblocking read of the array gives read-before-write for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            out_valid <= 1'b1;
            addr_err  <= (region == REG_NONE);
            case (region)
                REG_RAM:    out <= ram[ram_idx];
                REG_SCREEN: out <= screen[scr_idx];
                REG_KBD:    out <= kbd_rd;
                REG_STAT:   out <= kbd_stat;
                default:    out <= '0;
            endcase
        end
    end

endmodule

// File: doc/hack_mmio_memory.md
HACK_MMIO_MEMORY -- requirements
Module: hack_mmio_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data word width.
REQ-002 SHALL have parameter ADDR_W, default 15, word address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 16384, data RAM words at address 0..RAM_DEPTH-1.
REQ-004 SHALL have parameter SCREEN_DEPTH, default 8192, screen RAM words at RAM_DEPTH..RAM_DEPTH+SCREEN_DEPTH-1.
REQ-005 SHALL have parameter KBD_DEPTH, default 4, keyboard FIFO entries (power of two, 2..16).
REQ-006 SHALL have ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in  in  DATA_W  write data.
- load  in  1  write enable for the current address.
- address  in  ADDR_W  word address.
- out  out  DATA_W  registered read data.
- out_valid  out  1  out holds data for the address presented in the previous cycle.
- kbd_in  in  DATA_W  key code from keyboard source.
- kbd_push  in  1  enqueue kbd_in.
- kbd_full  out  1  keyboard FIFO full.
- addr_err  out  1  one-cycle pulse on access to an unmapped address.

Function
REQ-007 SHALL define KBD_ADDR = RAM_DEPTH+SCREEN_DEPTH and KBD_STAT = KBD_ADDR+1; all other addresses at or above KBD_ADDR+2 are unmapped.
REQ-008 SHALL write in to data or screen RAM at posedge when load=1 and address is in that region; no other region changes.
REQ-009 SHALL present read data on out one cycle after address (read latency 1), with out_valid=1 in that cycle for every cycle after the first following reset.
REQ-010 SHALL return old data on a read and write to the same RAM address in the same cycle (read-before-write).
REQ-011 SHALL, on a read of KBD_ADDR with load=0, return the FIFO head and pop it; an empty FIFO returns 0 and does not pop.
REQ-012 SHALL return {zero-padding, count} on a read of KBD_STAT, with no side effect.
REQ-013 SHALL ignore writes to KBD_ADDR and KBD_STAT; load=1 at KBD_ADDR does not pop.
REQ-014 SHALL drop kbd_push while full; kbd_full stays 1 and the count is unchanged.
REQ-015 SHALL perform a simultaneous push and pop on a non-empty FIFO in the same cycle, leaving the count unchanged.
REQ-016 SHALL treat a simultaneous push and pop on an empty FIFO as pop-empty: the read returns 0 and the pushed value is enqueued.
REQ-017 SHALL, on an unmapped address, return 0 on out, write nothing, and pulse addr_err the cycle after the access.
REQ-018 SHALL wrap FIFO pointers modulo KBD_DEPTH.

Reset
REQ-019 SHALL, while rst_n=0, force out=0, out_valid=0, addr_err=0, FIFO count=0, pointers=0 and kbd_full=0.
REQ-020 SHALL NOT clear RAM contents on reset.
REQ-021 SHALL discard an access in flight when reset asserts mid-cycle; out_valid returns 1 only after the first posedge following deassertion.

Configuration
REQ-022 SHALL honour macro HACK_MMIO_KBD_FIFO_EN:
- Defined: keyboard behaves per REQ-011..REQ-016.
- Undefined: keyboard is a single register loaded on kbd_push and never popped; KBD_ADDR reads return its value without side effect; KBD_STAT reads 0; kbd_full is tied to 0.

Structure
REQ-023 SHALL place in package hack_mem_pkg: the region enum (REG_RAM, REG_SCREEN, REG_KBD, REG_STAT, REG_NONE), default width and depth constants, and an address-decode function.
REQ-024 SHALL implement the keyboard FIFO as sub-module hack_kbd_fifo, instantiated only under HACK_MMIO_KBD_FIFO_EN.

Verification
REQ-025 SHALL cover these directed scenarios:
- Write FFFF to address 75 with load=1, then read 75 with load=0 -> out=FFFF one cycle later, out_valid=1.
- Write FFFF to 24000, read 24000 -> FFFF; write FFFF to 24576 -> ignored, FIFO count unchanged.
- Push 0041, 0042, read 24577 -> 0002; read 24576 twice -> 0041 then 0042; third read -> 0000.
- Push 5 keys with KBD_DEPTH=4 -> kbd_full=1 after the 4th; the 5th is dropped; pops return the first 4 in order.
- Read address 24578 -> out=0000 and addr_err high for exactly one cycle.
- Assert rst_n=0 mid-sequence with 2 queued keys -> out=0, out_valid=0, KBD_STAT reads 0 after release; RAM[75] still FFFF.
